// File: rtl/regbank_pkg.sv
// Shared defaults, address-width helper and port-index type for the multi-port register bank.
package regbank_pkg;

    localparam int unsigned REGBANK_DATA_W = 64;
    localparam int unsigned REGBANK_DEPTH  = 32;
    localparam int unsigned REGBANK_NUM_RD = 2;

    // Up to four read ports.
    typedef logic [1:0] portIdx_t;

    function automatic int unsigned addrWidth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regbank_rd_port.sv
// One registered read port: write-port address compare, forwarding mux and
// output registers that hold their data while the port is idle.
module regbank_rd_port #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] storedData,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid
);

    logic              fwdHit;
    logic [DATA_W-1:0] rdDataNext;

    // A same-cycle write wins over the stale stored value.
    always_comb begin
        fwdHit     = wrEn && (wrAddr == rdAddr);
        rdDataNext = fwdHit ? wrData : storedData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEn;
            if (rdEn) begin
                rdData <= rdDataNext;
            end
        end
    end

endmodule

// File: rtl/regbank_mp.sv
// Register bank with one write port and NUM_RD registered read ports with forwarding.
// Define REGBANK_ZERO_REG_EN to hardwire register 0 to zero.
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W = REGBANK_DATA_W,
    parameter int unsigned DEPTH  = REGBANK_DEPTH,
    parameter int unsigned NUM_RD = REGBANK_NUM_RD,
    localparam int unsigned ADDR_W = addrWidth(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);

    logic [DATA_W-1:0] storage [DEPTH];
    logic              wrEff;

    // With the zero register, a write to address 0 is dropped both from storage
    // and from forwarding, so register 0 reads back as 0 in every case.
    always_comb begin
`ifdef REGBANK_ZERO_REG_EN
        wrEff = wr_en && (wr_addr != '0);
`else
        wrEff = wr_en;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (wrEff) begin
            storage[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : gRdPort
        logic [ADDR_W-1:0] portAddr;
        assign portAddr = rd_addr[p*ADDR_W +: ADDR_W];

        regbank_rd_port #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) uRdPort (
            .clk       (clk),
            .rst_n     (rst_n),
            .rdEn      (rd_en[p]),
            .rdAddr    (portAddr),
            .storedData(storage[portAddr]),
            .wrEn      (wrEff),
            .wrAddr    (wr_addr),
            .wrData    (wr_data),
            .rdData    (rd_data[p*DATA_W +: DATA_W]),
            .rdValid   (rd_valid[p])
        );
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Self-checking bench for regbank_mp: default 64x32x2 instance and a 32x8x3 instance.
// Honours REGBANK_ZERO_REG_EN when deciding expected values.
module tb_regbank_mp;

    logic clk;
    logic rst_n;

    // Instance A: defaults.
    logic         wrEnA;
    logic [4:0]   wrAddrA;
    logic [63:0]  wrDataA;
    logic [1:0]   rdEnA;
    logic [9:0]   rdAddrA;
    logic [127:0] rdDataA;
    logic [1:0]   rdValidA;

    // Instance B: DATA_W=32, DEPTH=8, NUM_RD=3.
    logic        wrEnB;
    logic [2:0]  wrAddrB;
    logic [31:0] wrDataB;
    logic [2:0]  rdEnB;
    logic [8:0]  rdAddrB;
    logic [95:0] rdDataB;
    logic [2:0]  rdValidB;

    int nTests;
    int nFail;

    logic [63:0] memA [32];
    logic [31:0] memB [8];

    regbank_mp uDutA (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wrEnA),
        .wr_addr (wrAddrA),
        .wr_data (wrDataA),
        .rd_en   (rdEnA),
        .rd_addr (rdAddrA),
        .rd_data (rdDataA),
        .rd_valid(rdValidA)
    );

    regbank_mp #(
        .DATA_W(32),
        .DEPTH (8),
        .NUM_RD(3)
    ) uDutB (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wrEnB),
        .wr_addr (wrAddrB),
        .wr_data (wrDataB),
        .rd_en   (rdEnB),
        .rd_addr (rdAddrB),
        .rd_data (rdDataB),
        .rd_valid(rdValidB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit writeTakes(input logic en, input int addr);
`ifdef REGBANK_ZERO_REG_EN
        return en && (addr != 0);
`else
        return en;
`endif
    endfunction

    task automatic clearModels();
        for (int i = 0; i < 32; i++) memA[i] = '0;
        for (int i = 0; i < 8; i++) memB[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic writeA(input int addr, input logic [63:0] data);
        wrEnA   = 1'b1;
        wrAddrA = 5'(addr);
        wrDataA = data;
        step();
        if (writeTakes(1'b1, addr)) memA[addr] = data;
        wrEnA = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        nTests++;
        if (rdDataA !== '0) begin
            nFail++; $display("FAIL reset_rd_data_a: got %h expected 0", rdDataA);
        end
        nTests++;
        if (rdValidA !== '0) begin
            nFail++; $display("FAIL reset_rd_valid_a: got %b expected 0", rdValidA);
        end
        nTests++;
        if (rdDataB !== '0) begin
            nFail++; $display("FAIL reset_rd_data_b: got %h expected 0", rdDataB);
        end
        nTests++;
        if (rdValidB !== '0) begin
            nFail++; $display("FAIL reset_rd_valid_b: got %b expected 0", rdValidB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clearModels();

        writeA(5, 64'hDEAD_BEEF);
        rdEnA   = 2'b01;
        rdAddrA = {5'd0, 5'd5};
        step();
        rdEnA = 2'b00;
        nTests++;
        if (rdDataA[63:0] !== 64'hDEAD_BEEF) begin
            nFail++; $display("FAIL pre_reset_read: got %h expected %h", rdDataA[63:0], 64'hDEAD_BEEF);
        end

        // Pending write to reg 6 is cut off by a mid-cycle reset.
        wrEnA   = 1'b1;
        wrAddrA = 5'd6;
        wrDataA = 64'h1111_2222;
        #2;
        rst_n = 1'b0;
        #1;
        nTests++;
        if (rdDataA !== '0) begin
            nFail++; $display("FAIL async_reset_data: got %h expected 0", rdDataA);
        end
        nTests++;
        if (rdValidA !== '0) begin
            nFail++; $display("FAIL async_reset_valid: got %b expected 0", rdValidA);
        end
        @(posedge clk);
        @(negedge clk);
        wrEnA = 1'b0;
        rst_n = 1'b1;
        clearModels();

        rdEnA   = 2'b11;
        rdAddrA = {5'd6, 5'd5};
        step();
        rdEnA = 2'b00;
        nTests++;
        if (rdDataA[63:0] !== 64'h0) begin
            nFail++; $display("FAIL reset_cleared_reg5: got %h expected 0", rdDataA[63:0]);
        end
        nTests++;
        if (rdDataA[127:64] !== 64'h0) begin
            nFail++; $display("FAIL reset_aborted_write_reg6: got %h expected 0", rdDataA[127:64]);
        end
        nTests++;
        if (rdValidA !== 2'b11) begin
            nFail++; $display("FAIL reset_post_valid: got %b expected 11", rdValidA);
        end
    endtask

    task automatic test_basic();
        writeA(3, 64'h1234);
        rdEnA   = 2'b01;
        rdAddrA = {5'd0, 5'd3};
        step();
        nTests++;
        if (rdDataA[63:0] !== 64'h1234) begin
            nFail++; $display("FAIL basic_read: got %h expected %h", rdDataA[63:0], 64'h1234);
        end
        nTests++;
        if (rdValidA !== 2'b01) begin
            nFail++; $display("FAIL basic_valid: got %b expected 01", rdValidA);
        end
        rdEnA   = 2'b00;
        rdAddrA = {5'd9, 5'd9};
        step();
        nTests++;
        if (rdDataA[63:0] !== 64'h1234) begin
            nFail++; $display("FAIL basic_hold: got %h expected %h", rdDataA[63:0], 64'h1234);
        end
        nTests++;
        if (rdValidA !== 2'b00) begin
            nFail++; $display("FAIL basic_valid_drop: got %b expected 00", rdValidA);
        end
    endtask

    task automatic test_forward();
        writeA(7, 64'h5555);
        wrEnA   = 1'b1;
        wrAddrA = 5'd7;
        wrDataA = 64'hAAAA;
        rdEnA   = 2'b11;
        rdAddrA = {5'd7, 5'd7};
        step();
        memA[7] = 64'hAAAA;
        wrEnA   = 1'b0;
        rdEnA   = 2'b00;
        for (int p = 0; p < 2; p++) begin
            nTests++;
            if (rdDataA[p*64 +: 64] !== 64'hAAAA) begin
                nFail++;
                $display("FAIL forward_port%0d: got %h expected %h", p, rdDataA[p*64 +: 64], 64'hAAAA);
            end
        end
        nTests++;
        if (rdValidA !== 2'b11) begin
            nFail++; $display("FAIL forward_valid: got %b expected 11", rdValidA);
        end
    endtask

    task automatic test_multiport();
        logic [63:0] exp0;
        logic [63:0] exp1;
        for (int a = 1; a < 32; a++) writeA(a, 64'(a * 3));
        rdEnA = 2'b11;
        for (int i = 0; i < 32; i++) begin
            rdAddrA = {5'(31 - i), 5'(i)};
            step();
            exp0 = 64'(i * 3);
            exp1 = 64'((31 - i) * 3);
            nTests++;
            if (rdDataA[63:0] !== exp0) begin
                nFail++; $display("FAIL multiport_p0_a%0d: got %h expected %h", i, rdDataA[63:0], exp0);
            end
            nTests++;
            if (rdDataA[127:64] !== exp1) begin
                nFail++;
                $display("FAIL multiport_p1_a%0d: got %h expected %h", 31 - i, rdDataA[127:64], exp1);
            end
            nTests++;
            if (rdValidA !== 2'b11) begin
                nFail++; $display("FAIL multiport_valid_%0d: got %b expected 11", i, rdValidA);
            end
        end
        rdEnA = 2'b00;
    endtask

    task automatic test_zero_reg();
        logic [63:0] expZ;
`ifdef REGBANK_ZERO_REG_EN
        expZ = 64'h0;
`else
        expZ = 64'hFFFF;
`endif
        wrEnA   = 1'b1;
        wrAddrA = 5'd0;
        wrDataA = 64'hFFFF;
        rdEnA   = 2'b11;
        rdAddrA = {5'd0, 5'd0};
        for (int c = 0; c < 2; c++) begin
            step();
            wrEnA = 1'b0;
            for (int p = 0; p < 2; p++) begin
                nTests++;
                if (rdDataA[p*64 +: 64] !== expZ) begin
                    nFail++;
                    $display("FAIL zero_reg_c%0d_p%0d: got %h expected %h", c, p, rdDataA[p*64 +: 64], expZ);
                end
            end
        end
        rdEnA = 2'b00;
    endtask

    task automatic test_random_sweep();
        logic [31:0] expData [3];
        logic        expValid [3];
        int          ra [3];
        int          wa;
        for (int p = 0; p < 3; p++) begin
            expData[p]  = '0;
            expValid[p] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            wa      = int'($urandom_range(0, 7));
            wrEnB   = 1'($urandom_range(0, 1));
            wrAddrB = 3'(wa);
            wrDataB = $urandom;
            rdEnB   = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                ra[p] = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
                rdAddrB[p*3 +: 3] = 3'(ra[p]);
            end
            for (int p = 0; p < 3; p++) begin
                expValid[p] = rdEnB[p];
                if (rdEnB[p]) begin
                    if (writeTakes(wrEnB, wa) && ra[p] == wa) expData[p] = wrDataB;
                    else expData[p] = memB[ra[p]];
                end
            end
            if (writeTakes(wrEnB, wa)) memB[wa] = wrDataB;
            step();
            for (int p = 0; p < 3; p++) begin
                nTests++;
                if (rdDataB[p*32 +: 32] !== expData[p]) begin
                    nFail++;
                    $display("FAIL sweep_data_n%0d_p%0d: got %h expected %h", n, p,
                             rdDataB[p*32 +: 32], expData[p]);
                end
                nTests++;
                if (rdValidB[p] !== expValid[p]) begin
                    nFail++;
                    $display("FAIL sweep_valid_n%0d_p%0d: got %b expected %b", n, p,
                             rdValidB[p], expValid[p]);
                end
            end
        end
        wrEnB = 1'b0;
        rdEnB = '0;
    endtask

    initial begin
        nTests  = 0;
        nFail   = 0;
        rst_n   = 1'b0;
        wrEnA   = 1'b0;
        wrAddrA = '0;
        wrDataA = '0;
        rdEnA   = '0;
        rdAddrA = '0;
        wrEnB   = 1'b0;
        wrAddrB = '0;
        wrDataB = '0;
        rdEnB   = '0;
        rdAddrB = '0;
        clearModels();

        test_reset();
        test_basic();
        test_forward();
        test_multiport();
        test_zero_reg();
        test_random_sweep();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
